// File: rtl/mem8085_pkg.sv
// Shared constants and state encoding for the 8085 word memory and its
// block-copy bus master.
//   MEM_AW / MEM_DW : address and data width of the 256x16 word memory
//   copy_state_t    : sequencer states (IDLE, RD, WR, DONE)
package mem8085_pkg;
    localparam int MEM_AW = 8;
    localparam int MEM_DW = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } copy_state_t;
endpackage

// File: rtl/mem_copy_master_8085.sv
// Block-copy bus master for the 8085 datapath's word memory. On an accepted
// start it alternates one read cycle and one write cycle per word, moving
// len words from src to dst (forward, word by word, pointers wrap mod 2^AW).
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   start, src, dst, len  : command; sampled only in IDLE
//   busy, done            : busy in RD/WR, done is a one-cycle pulse
//   count, sum            : words written, modulo-2^DW sum of copied words
//   mem_addr, mem_read,
//   mem_write, mem_wdata  : memory master port (all registered)
//   mem_rdata             : combinational read data from the memory
module mem_copy_master_8085
    import mem8085_pkg::*;
#(
    parameter int AW = MEM_AW,
    parameter int DW = MEM_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [AW-1:0] len,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] count,
    output logic [DW-1:0] sum,
    output logic [AW-1:0] mem_addr,
    output logic          mem_read,
    output logic          mem_write,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    copy_state_t   state;
    logic [AW-1:0] src_ptr;
    logic [AW-1:0] dst_ptr;
    logic [AW-1:0] len_q;
    logic [AW-1:0] count_inc;

    assign count_inc = AW'(count + 1'b1);

    // All bus outputs are set up one edge ahead for the state being entered,
    // so every port is a plain flop. mem_wdata doubles as the word buffer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            src_ptr   <= '0;
            dst_ptr   <= '0;
            len_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            count     <= '0;
            sum       <= '0;
            mem_addr  <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        count <= '0;
                        sum   <= '0;
                        if (len != '0) begin
                            src_ptr  <= src;
                            dst_ptr  <= dst;
                            len_q    <= len;
                            state    <= RD;
                            busy     <= 1'b1;
                            mem_addr <= src;
                            mem_read <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                RD: begin
                    mem_wdata <= mem_rdata;
                    sum       <= sum + mem_rdata;
                    src_ptr   <= src_ptr + 1'b1;
                    state     <= WR;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b1;
                    mem_addr  <= dst_ptr;
                end
                WR: begin
                    dst_ptr   <= dst_ptr + 1'b1;
                    count     <= count_inc;
                    mem_write <= 1'b0;
                    if (count_inc == len_q) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        mem_addr <= '0;
                    end else begin
                        state    <= RD;
                        mem_read <= 1'b1;
                        // src_ptr already advanced in the RD cycle
                        mem_addr <= src_ptr;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_copy_master_8085.sv
// Bench for mem_copy_master_8085: a behavioural 256x16 memory responds on the
// master port; expected writes are queued per command and a monitor pops and
// compares them as the DUT issues each write cycle.
module tb_mem_copy_master_8085;
    import mem8085_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [MEM_AW-1:0] src, dst, len;
    logic              busy, done;
    logic [MEM_AW-1:0] count;
    logic [MEM_DW-1:0] sum;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_read, mem_write;
    logic [MEM_DW-1:0] mem_wdata, mem_rdata;

    logic [MEM_DW-1:0] mem [256];
    logic              pl_en;
    logic [MEM_AW-1:0] pl_addr;
    logic [MEM_DW-1:0] pl_data;

    int errors = 0;
    int checks = 0;
    int acc_cnt = 0;
    logic [MEM_AW+MEM_DW-1:0] exp_q [$];

    always #5 clk = ~clk;

    mem_copy_master_8085 dut (
        .clk(clk), .rst_n(rst_n), .start(start), .src(src), .dst(dst), .len(len),
        .busy(busy), .done(done), .count(count), .sum(sum),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // memory model: combinational read, write on rising edge, bench preload port
    assign mem_rdata = mem_read ? mem[mem_addr] : '0;
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (mem_write) mem[mem_addr] <= mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // write monitor / scoreboard
    always @(negedge clk) begin
        if (mem_read || mem_write) begin
            acc_cnt++;
            chk("rd_wr_exclusive", {31'd0, mem_read & mem_write}, 32'd0);
        end
        if (mem_write) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {8'd0, mem_addr, mem_wdata}, 32'hFFFF_FFFF);
            end else begin
                logic [MEM_AW+MEM_DW-1:0] e;
                e = exp_q.pop_front();
                chk("write_addr", {24'd0, mem_addr}, {24'd0, e[MEM_AW+MEM_DW-1:MEM_DW]});
                chk("write_data", {16'd0, mem_wdata}, {16'd0, e[MEM_DW-1:0]});
            end
        end
    end

    task automatic preload(input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic expect_wr(input logic [7:0] a, input logic [15:0] d);
        exp_q.push_back({a, d});
    endtask

    // Issue one command and check done timing, busy length, bus activity,
    // count and sum. poke pulses start with junk operands in the 3rd cycle.
    task automatic run_cmd(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                           input logic [15:0] exp_sum, input bit poke);
        int busy_cyc = 0;
        int done_at = 0;
        int acc0;
        @(negedge clk);
        acc0 = acc_cnt;
        start = 1'b1; src = s; dst = d; len = l;
        @(negedge clk);
        start = 1'b0; src = 8'h5A; dst = 8'hA5; len = 8'h77;
        for (int c = 1; c <= 600 && done_at == 0; c++) begin
            if (c > 1) @(negedge clk);
            start = 1'b0;
            if (poke && c == 3) begin
                start = 1'b1; src = 8'h00; dst = 8'h90; len = 8'd1;
            end
            if (busy) busy_cyc++;
            if (done) done_at = c;
        end
        chk("done_cycle", done_at, 2 * int'(l) + 1);
        chk("busy_cycles", busy_cyc, 2 * int'(l));
        chk("count", {24'd0, count}, {24'd0, l});
        chk("sum", {16'd0, sum}, {16'd0, exp_sum});
        @(negedge clk);
        chk("done_pulse_len", {31'd0, done}, 32'd0);
        chk("bus_accesses", acc_cnt - acc0, 2 * int'(l));
        chk("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; src = '0; dst = '0; len = '0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_rw", {30'd0, mem_read, mem_write}, 0);
        chk("rst_addr", {24'd0, mem_addr}, 0);
        chk("rst_wdata", {16'd0, mem_wdata}, 0);
        chk("rst_count_sum", {8'd0, count, sum}, 0);
        rst_n = 1'b1;

        // basic copy with a start pulse while busy
        for (int k = 0; k < 4; k++) preload(8'(128 + k), 16'(10 * k));
        expect_wr(8'h10, 16'd0); expect_wr(8'h11, 16'd10);
        expect_wr(8'h12, 16'd20); expect_wr(8'h13, 16'd30);
        run_cmd(8'h80, 8'h10, 8'd4, 16'd60, 1'b1);
        chk("mem_10", {16'd0, mem[8'h10]}, 0);
        chk("mem_13", {16'd0, mem[8'h13]}, 30);
        chk("mem_90_untouched", {16'd0, mem[8'h90]}, 0);

        // zero length
        run_cmd(8'h33, 8'h44, 8'd0, 16'd0, 1'b0);

        // address wrap
        preload(8'hFE, 16'h1111); preload(8'hFF, 16'h2222); preload(8'h00, 16'h3333);
        expect_wr(8'h40, 16'h1111); expect_wr(8'h41, 16'h2222); expect_wr(8'h42, 16'h3333);
        run_cmd(8'hFE, 8'h40, 8'd3, 16'h6666, 1'b0);
        chk("mem_42", {16'd0, mem[8'h42]}, 32'h3333);

        // overlapping forward copy replicates
        preload(8'h20, 16'hAAAA);
        expect_wr(8'h21, 16'hAAAA); expect_wr(8'h22, 16'hAAAA); expect_wr(8'h23, 16'hAAAA);
        run_cmd(8'h20, 8'h21, 8'd3, 16'hFFFE, 1'b0);
        chk("mem_23", {16'd0, mem[8'h23]}, 32'hAAAA);

        // sum overflow
        preload(8'h60, 16'hFFFF); preload(8'h61, 16'hFFFF);
        expect_wr(8'h70, 16'hFFFF); expect_wr(8'h71, 16'hFFFF);
        run_cmd(8'h60, 8'h70, 8'd2, 16'hFFFE, 1'b0);

        // reset during the second WR: that write commits, the rest never happen
        for (int k = 0; k < 4; k++) preload(8'(8'h50 + k), 16'hDEAD);
        expect_wr(8'h50, 16'd0); expect_wr(8'h51, 16'd10);
        @(negedge clk);
        start = 1'b1; src = 8'h80; dst = 8'h50; len = 8'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);      // now in cycle 4: second WR
        chk("pre_rst_in_wr", {31'd0, mem_write}, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy_done", {30'd0, busy, done}, 0);
        chk("abort_rw", {30'd0, mem_read, mem_write}, 0);
        chk("abort_addr_wdata", {8'd0, mem_addr, mem_wdata}, 0);
        chk("abort_count_sum", {8'd0, count, sum}, 0);
        rst_n = 1'b1;
        chk("abort_mem_51", {16'd0, mem[8'h51]}, 10);
        chk("abort_mem_52", {16'd0, mem[8'h52]}, 32'hDEAD);
        chk("abort_mem_53", {16'd0, mem[8'h53]}, 32'hDEAD);
        chk("abort_queue", exp_q.size(), 0);

        // fresh command after abort
        expect_wr(8'hB0, 16'd20); expect_wr(8'hB1, 16'd30);
        run_cmd(8'h82, 8'hB0, 8'd2, 16'd50, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_copy_master_8085.md
# mem_copy_master_8085

Bus-master sequencer for the multi-cycle 8085 datapath's 256×16 word memory. It accepts a block-copy command and issues read cycles and then write cycles on the memory port, moving `len` words from `src` to `dst`. It sits beside the core as a second initiator on the memory's `addr/read/write/dataw/data` interface. Arbitration with the core is outside this block: the core must not drive the memory while `busy` is high.

## Interface
Parameters:
- `AW`, default 8: memory address width.
- `DW`, default 16: memory word width.

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `start` input 1: command strobe; sampled only in IDLE.
- `src` input AW: first source address; latched on accepted `start`.
- `dst` input AW: first destination address; latched on accepted `start`.
- `len` input AW: word count; latched on accepted `start`; 0 means no transfer.
- `busy` output 1: high in RD and WR states.
- `done` output 1: one-cycle pulse in DONE state.
- `count` output AW: words written so far in the current or last command.
- `sum` output DW: modulo-2^DW sum of all words copied by the last command.
- `mem_addr` output AW: memory address.
- `mem_read` output 1: memory read enable; read data is combinational.
- `mem_write` output 1: memory write enable; the memory writes on the rising edge.
- `mem_wdata` output DW: write data.
- `mem_rdata` input DW: read data; valid in the same cycle `mem_read` is high.

## Operation
- States: IDLE, RD, WR, DONE. All outputs are registered or decoded from state and registers.
- IDLE:
  - If `start`=1 and `len`≠0, latch `src`, `dst`, `len`, clear `count` and `sum`, then go to RD.
  - If `start`=1 and `len`=0, clear `count` and `sum`, then go to DONE. No memory access occurs.
- RD:
  - Drive `mem_addr`=src_ptr, `mem_read`=1.
  - At the edge, capture `mem_rdata` into buf, add it to `sum`, and increment src_ptr.
  - Go to WR.
- WR:
  - Drive `mem_addr`=dst_ptr, `mem_write`=1, `mem_wdata`=buf.
  - At the edge, increment dst_ptr and `count`.
  - If `count`+1 equals latched len, go to DONE; otherwise go to RD.
- DONE: `done`=1 for one cycle, then go unconditionally to IDLE.
- `start` outside IDLE, including in DONE, is ignored. Inputs may change freely after acceptance.
- Pointers are AW-bit and wrap modulo 256; 0xFF+1 = 0x00.
- Copy is always forward and word by word. If dst lies in (src, src+len), already-copied words are re-read. This replication is the defined behaviour.
- `sum` wraps modulo 2^16. `count` and `sum` hold their values in IDLE until the next accepted `start`.
- Idle bus state: `mem_addr`=0, `mem_read`=0, `mem_write`=0. `mem_wdata` holds buf.
- `mem_read` and `mem_write` are never high in the same cycle.

## Timing
- Reset (`rst_n`=0 at an edge): state=IDLE; `busy`, `done`, `mem_read`, `mem_write` are 0; `mem_addr`, `mem_wdata`, `count`, `sum` are 0.
- Reset mid-command aborts at that edge. Words already written stay in memory. A WR cycle coinciding with the reset edge is still committed by the memory.
- `start` accepted at edge E0: the first RD cycle follows E0, the first WR is one cycle later.
- Each word takes 2 cycles. `busy` is high for exactly 2·len cycles.
- `done` is high in the cycle after the last WR. IDLE follows one cycle later, so the earliest next `start` is sampled 2·len+2 edges after E0.
- With `len`=0: `done` is high in the cycle right after E0, and `busy` never rises.

## Structure
- Shared package `mem8085_pkg`: AW/DW constants and a 2-bit state enum (IDLE, RD, WR, DONE). The bench's memory model imports the same constants.
- Single flat module; no sub-module is needed. The bench instantiates the existing memory model as the responder.

## Test plan
- Preload mem[128+k]=10·k. Send src=0x80, dst=0x10, len=4. Required: mem[0x10..0x13]=0,10,20,30; `sum`=60; `count`=4; `busy` high 8 cycles; `done` pulses once, at edge 9.
- Send len=0 with any src/dst. Required: `done` the cycle after start, no `mem_read`/`mem_write` activity, `count`=0, `sum`=0.
- Wrap: preload mem[0xFE]=0x1111, mem[0xFF]=0x2222, mem[0x00]=0x3333. Send src=0xFE, dst=0x40, len=3. Required: mem[0x40..0x42]=0x1111, 0x2222, 0x3333; `sum`=0x6666.
- Overlap: preload mem[0x20]=0xAAAA. Send src=0x20, dst=0x21, len=3. Required: mem[0x21..0x23] all 0xAAAA.
- Pulse `start` with new operands while `busy` is high. Required: the command is ignored and the original transfer completes unchanged. Separately, assert `rst_n`=0 after the second WR of a len=4 copy. Required: next cycle all outputs are at their reset values, only 2 destination words are modified, and a fresh command afterwards runs correctly.
- Sum overflow: preload two words of 0xFFFF and copy them (len=2). Required: `sum`=0xFFFE; `mem_read` and `mem_write` are never high together throughout.
